// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg
// Shared definitions for the reset sequencer slice: the sequencer state
// encoding and small width helpers used to size counters from parameters.
package reset_seq_pkg;

  // Sequencer states: button held, minimum hold, staggered release, running.
  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } seq_state_t;

  // $clog2 that never returns zero, so a counter always has at least one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce
// Synchronises the raw reset button into the Clk domain and filters it so
// the output level only changes after DEBOUNCE_CYCLES consecutive samples
// that disagree with the current filtered level.
//
// Ports:
//   Clk      - system clock, rising edge
//   Reset    - synchronous active-high clear of synchroniser and filter
//   BTNS     - raw asynchronous button, active-high
//   filtered - debounced button level
module button_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic BTNS,
  output logic filtered
);
  import reset_seq_pkg::*;

  localparam int CW = clog2_min1(DEBOUNCE_CYCLES);

  // Power-up values let the block come out of configuration quiet.
  logic [SYNC_STAGES-1:0] sync_q = '0;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   filt_q = 1'b0;
  logic                   filt_d;
  logic [CW-1:0]          cnt_q  = '0;
  logic [CW-1:0]          cnt_d;
  logic                   synced;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign filtered = filt_q;

  // Shift the button into the synchroniser chain; count consecutive
  // disagreements and flip the filtered level on the last one. Any
  // agreement clears the count, so glitches never accumulate.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], BTNS};
    filt_d = filt_q;
    cnt_d  = '0;
    if (synced != filt_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = ~filt_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
// Generates CHANNELS per-domain resets that assert together and release one
// at a time (bit 0 first) after a minimum hold, with STAGGER_CYCLES between
// releases. Causes: block Reset, debounced button, one-cycle software request.
//
// Ports:
//   Clk       - system clock, rising edge
//   Reset     - synchronous active-high block reset, highest priority
//   BTNS      - raw asynchronous reset button, active-high
//   Sw_Req    - single-cycle software reset request, active-high
//   Reset_Out - per-domain resets, active-high
//   Ready     - high once every Reset_Out bit is released
module reset_sequencer #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int HOLD_CYCLES     = 8,
  parameter int STAGGER_CYCLES  = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                BTNS,
  input  logic                Sw_Req,
  output logic [CHANNELS-1:0] Reset_Out,
  output logic                Ready
);
  import reset_seq_pkg::*;

  localparam int CW = clog2_min1(max3(HOLD_CYCLES, STAGGER_CYCLES, DEBOUNCE_CYCLES));
  localparam int IW = clog2_min1(CHANNELS);

  // Power-up values make the block self-sequence without a Reset pulse.
  seq_state_t          state_q = ST_HOLD;
  seq_state_t          state_d;
  logic [CW-1:0]       cnt_q   = '0;
  logic [CW-1:0]       cnt_d;
  logic [IW-1:0]       idx_q   = '0;
  logic [IW-1:0]       idx_d;
  logic [CHANNELS-1:0] out_q   = '1;
  logic [CHANNELS-1:0] out_d;
  logic                ready_q = 1'b0;
  logic                ready_d;
  logic                filtered;

  button_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .Clk     (Clk),
    .Reset   (Reset),
    .BTNS    (BTNS),
    .filtered(filtered)
  );

  assign Reset_Out = out_q;
  assign Ready     = ready_q;

  // Next-state logic. The button overrides everything, then the software
  // request (ignored while the button holds ASSERT), then normal sequencing.
  // Counters always clear at their terminal value so they never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    out_d   = out_q;
    ready_d = ready_q;

    if (filtered) begin
      state_d = ST_ASSERT;
      out_d   = '1;
      ready_d = 1'b0;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (Sw_Req && (state_q != ST_ASSERT)) begin
      state_d = ST_HOLD;
      out_d   = '1;
      ready_d = 1'b0;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
        ST_HOLD: begin
          if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
            out_d[0] = 1'b0;
            cnt_d    = '0;
            // A single domain finishes on its own release edge.
            if (CHANNELS == 1) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end else begin
              idx_d   = IW'(1);
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_q == CW'(STAGGER_CYCLES - 1)) begin
            for (int k = 0; k < CHANNELS; k++) begin
              if (idx_q == IW'(k)) begin
                out_d[k] = 1'b0;
              end
            end
            cnt_d = '0;
            if (idx_q == IW'(CHANNELS - 1)) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_RUN: begin
          out_d   = '0;
          ready_d = 1'b1;
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= '1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
// Directed bench for reset_sequencer. Stimulus pushes the expected output
// changes (edge number, Reset_Out, Ready) into per-DUT queues; monitors pop
// an entry whenever a DUT's outputs change and compare value and edge.
// A second instance with CHANNELS=1 shares Clk and Reset.
module tb_reset_sequencer;

  typedef struct {
    int         cyc;
    logic [3:0] val;
    logic       rdy;
  } ev_t;

  logic       Clk    = 1'b0;
  logic       Reset  = 1'b1;
  logic       BTNS   = 1'b0;
  logic       Sw_Req = 1'b0;
  logic [3:0] Reset_Out;
  logic       Ready;
  logic [0:0] ro1;
  logic       rdy1;

  int  cyc   = 0;
  int  nVec  = 0;
  int  nFail = 0;
  ev_t q0[$];
  ev_t q1[$];

  reset_sequencer dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .BTNS     (BTNS),
    .Sw_Req   (Sw_Req),
    .Reset_Out(Reset_Out),
    .Ready    (Ready)
  );

  reset_sequencer #(.CHANNELS(1)) dut1 (
    .Clk      (Clk),
    .Reset    (Reset),
    .BTNS     (1'b0),
    .Sw_Req   (1'b0),
    .Reset_Out(ro1),
    .Ready    (rdy1)
  );

  // Free-running clock and edge counter; after edge n, cyc == n.
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor for the 4-channel instance: every output change must match the
  // oldest expected change, both in value and in the edge it happened on.
  logic [4:0] prev0 = 5'b11110;
  always @(negedge Clk) begin
    logic [4:0] cur;
    ev_t e;
    cur = {Reset_Out, Ready};
    if (cur !== prev0) begin
      nVec++;
      if (q0.size() == 0) begin
        nFail++;
        $display("[TB] FAIL ch4_unexpected cyc=%0d got out=%b rdy=%b, required no change", cyc, Reset_Out, Ready);
      end else begin
        e = q0.pop_front();
        if (e.cyc != cyc || cur !== {e.val, e.rdy}) begin
          nFail++;
          $display("[TB] FAIL ch4_event got out=%b rdy=%b at cyc=%0d, required out=%b rdy=%b at cyc=%0d",
                   Reset_Out, Ready, cyc, e.val, e.rdy, e.cyc);
        end
      end
      prev0 = cur;
    end
  end

  // Monitor for the single-channel instance.
  logic [1:0] prev1 = 2'b10;
  always @(negedge Clk) begin
    logic [1:0] cur;
    ev_t e;
    cur = {ro1, rdy1};
    if (cur !== prev1) begin
      nVec++;
      if (q1.size() == 0) begin
        nFail++;
        $display("[TB] FAIL ch1_unexpected cyc=%0d got out=%b rdy=%b, required no change", cyc, ro1, rdy1);
      end else begin
        e = q1.pop_front();
        if (e.cyc != cyc || cur !== {e.val[0], e.rdy}) begin
          nFail++;
          $display("[TB] FAIL ch1_event got out=%b rdy=%b at cyc=%0d, required out=%b rdy=%b at cyc=%0d",
                   ro1, rdy1, cyc, e.val[0], e.rdy, e.cyc);
        end
      end
      prev1 = cur;
    end
  end

  task automatic tickTo(input int n);
    while (cyc < n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic btn, input logic sw);
    Reset  = rst;
    BTNS   = btn;
    Sw_Req = sw;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] actOut, input logic actRdy,
                             input logic [3:0] expOut, input logic expRdy);
    nVec++;
    if (actOut !== expOut || actRdy !== expRdy) begin
      nFail++;
      $display("[TB] FAIL %s cyc=%0d got out=%b rdy=%b, required out=%b rdy=%b",
               name, cyc, actOut, actRdy, expOut, expRdy);
    end
  endtask

  task automatic push0(input int c, input logic [3:0] v, input logic r);
    ev_t e;
    e.cyc = c; e.val = v; e.rdy = r;
    q0.push_back(e);
  endtask

  task automatic push1(input int c, input logic v, input logic r);
    ev_t e;
    e.cyc = c; e.val = {3'b000, v}; e.rdy = r;
    q1.push_back(e);
  endtask

  // Full staggered release after the last edge before hold counting starts:
  // bit k falls on base + 8 + 4k, Ready with the last one.
  task automatic pushRel(input int base);
    logic [3:0] v;
    for (int k = 0; k < 4; k++) begin
      v = 4'b1111;
      v = v << (k + 1);
      push0(base + 8 + 4 * k, v, (k == 3));
    end
  endtask

  initial begin
    int b, s, w1, x, r;

    // Block reset for three edges, then the power-on release sequence.
    applyStimulus(1'b1, 1'b0, 1'b0);
    tickTo(2);
    checkOutput("reset_held_ch4", Reset_Out, Ready, 4'b1111, 1'b0);
    checkOutput("reset_held_ch1", {3'b000, ro1}, rdy1, 4'b0001, 1'b0);
    tickTo(3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    pushRel(3);
    push1(11, 1'b0, 1'b1);
    tickTo(30);
    checkOutput("run_after_reset", Reset_Out, Ready, 4'b0000, 1'b1);

    // Five-cycle button glitch is filtered out.
    applyStimulus(1'b0, 1'b1, 1'b0);
    tickTo(35);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tickTo(60);
    checkOutput("short_glitch", Reset_Out, Ready, 4'b0000, 1'b1);

    // Thirty-cycle press: assert 11 edges after the rise, hold until the
    // filter drops, then a full release from the HOLD entry edge.
    b = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0);
    push0(b + 11, 4'b1111, 1'b0);
    tickTo(b + 30);
    applyStimulus(1'b0, 1'b0, 1'b0);
    pushRel(b + 41);
    tickTo(b + 70);
    checkOutput("run_after_button", Reset_Out, Ready, 4'b0000, 1'b1);

    // Button lands after bits 0 and 1 have released.
    s = cyc + 1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    push0(s, 4'b1111, 1'b0);
    tickTo(s);
    applyStimulus(1'b0, 1'b0, 1'b0);
    push0(s + 8, 4'b1110, 1'b0);
    push0(s + 12, 4'b1100, 1'b0);
    tickTo(s + 3);
    applyStimulus(1'b0, 1'b1, 1'b0);
    push0(s + 14, 4'b1111, 1'b0);
    tickTo(s + 13);
    checkOutput("two_released", Reset_Out, Ready, 4'b1100, 1'b0);
    tickTo(s + 23);
    applyStimulus(1'b0, 1'b0, 1'b0);
    pushRel(s + 34);
    tickTo(s + 65);

    // Software request, then a second one at hold count 5 restarts the hold.
    w1 = cyc + 1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    push0(w1, 4'b1111, 1'b0);
    tickTo(w1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tickTo(w1 + 5);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tickTo(w1 + 6);
    applyStimulus(1'b0, 1'b0, 1'b0);
    pushRel(w1 + 6);
    tickTo(w1 + 8);
    checkOutput("hold_restarted", Reset_Out, Ready, 4'b1111, 1'b0);
    tickTo(w1 + 40);

    // Software request while the button holds ASSERT changes nothing.
    x = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0);
    push0(x + 11, 4'b1111, 1'b0);
    tickTo(x + 14);
    applyStimulus(1'b0, 1'b1, 1'b1);
    tickTo(x + 15);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tickTo(x + 20);
    applyStimulus(1'b0, 1'b0, 1'b0);
    pushRel(x + 31);
    tickTo(x + 60);

    // Block reset in the middle of the release restarts both instances.
    r = cyc + 1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    push0(r, 4'b1111, 1'b0);
    tickTo(r);
    applyStimulus(1'b0, 1'b0, 1'b0);
    push0(r + 8, 4'b1110, 1'b0);
    push0(r + 12, 4'b1100, 1'b0);
    tickTo(r + 13);
    applyStimulus(1'b1, 1'b0, 1'b0);
    push0(r + 14, 4'b1111, 1'b0);
    push1(r + 14, 1'b1, 1'b0);
    tickTo(r + 14);
    applyStimulus(1'b0, 1'b0, 1'b0);
    pushRel(r + 14);
    push1(r + 22, 1'b0, 1'b1);
    tickTo(r + 15);
    checkOutput("reset_midrelease", Reset_Out, Ready, 4'b1111, 1'b0);
    tickTo(r + 50);

    // Any expected change still queued never happened.
    for (int i = 0; i < 100 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge Clk);
    while (q0.size() != 0) begin
      ev_t e;
      e = q0.pop_front();
      nVec++;
      nFail++;
      $display("[TB] FAIL ch4_missing got no change, required out=%b rdy=%b at cyc=%0d", e.val, e.rdy, e.cyc);
    end
    while (q1.size() != 0) begin
      ev_t e;
      e = q1.pop_front();
      nVec++;
      nFail++;
      $display("[TB] FAIL ch1_missing got no change, required out=%b rdy=%b at cyc=%0d", e.val[0], e.rdy, e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
